// File: rtl/paddle_renderer_if.sv
// paddle_renderer_if: frame tick / paddle position in, VGA pixel-write port and status out
interface paddle_renderer_if;
  logic       frame_tick;
  logic [9:0] paddle_x;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;
  modport master (
    output frame_tick, paddle_x,
    input  vga_x, vga_y, vga_colour, plot, busy, done
  );
  modport slave (
    input  frame_tick, paddle_x,
    output vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/paddle_renderer.sv
// paddle_renderer: erases the old paddle rectangle and plots the new one into the VGA frame buffer once per frame
//   clk, resetn (async, active-high)
//   bus.frame_tick/paddle_x in; bus.vga_x/vga_y/vga_colour/plot pixel writes out; bus.busy/done status out
module paddle_renderer #(
  parameter int         HALF_W   = 40,
  parameter int         HEIGHT   = 4,
  parameter int         PADDLE_Y = 460,
  parameter int         SCREEN_W = 640,
  parameter logic [2:0] COLOUR   = 3'b111,
  parameter int         RESET_X  = 320
) (
  input logic              clk,
  input logic              resetn,
  paddle_renderer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIN} state_t;
  localparam logic [10:0] HW   = 11'(HALF_W);
  localparam logic [10:0] XMAX = 11'(SCREEN_W - 1);
  localparam logic [8:0]  Y0   = 9'(PADDLE_Y);
  localparam logic [8:0]  Y1   = 9'(PADDLE_Y + HEIGHT - 1);
  state_t     state;
  logic [9:0] new_x;
  logic [9:0] drawn_x;
  logic       first_draw;
  logic [9:0] cur;
  // 11-bit arithmetic: bit 10 of the difference flags an underflow past column 0
  function automatic logic [9:0] lo(input logic [9:0] c);
    logic [10:0] d;
    d = {1'b0, c} - HW;
    return d[10] ? 10'd0 : d[9:0];
  endfunction
  function automatic logic [9:0] hi(input logic [9:0] c);
    logic [10:0] s;
    s = {1'b0, c} + HW;
    return s > XMAX ? XMAX[9:0] : s[9:0];
  endfunction
  assign cur = state == ERASE ? drawn_x : new_x;
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state          <= IDLE;
      new_x          <= '0;
      drawn_x        <= 10'(RESET_X);
      first_draw     <= 1'b1;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.plot       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.frame_tick) begin
          new_x <= bus.paddle_x;
          if (first_draw) begin
            state          <= DRAW;
            bus.vga_x      <= lo(bus.paddle_x);
            bus.vga_y      <= Y0;
            bus.vga_colour <= COLOUR;
            bus.plot       <= 1'b1;
            bus.busy       <= 1'b1;
          end else if (bus.paddle_x == drawn_x) begin
            state    <= FIN;
            bus.done <= 1'b1;
          end else begin
            state          <= ERASE;
            bus.vga_x      <= lo(drawn_x);
            bus.vga_y      <= Y0;
            bus.vga_colour <= 3'b000;
            bus.plot       <= 1'b1;
            bus.busy       <= 1'b1;
          end
        end
        ERASE, DRAW: begin
          if (bus.vga_x != hi(cur)) begin
            bus.vga_x <= bus.vga_x + 10'd1;
          end else if (bus.vga_y != Y1) begin
            bus.vga_x <= lo(cur);
            bus.vga_y <= bus.vga_y + 9'd1;
          end else if (state == ERASE) begin
            // erase ends straight into the draw sweep with no idle cycle
            state          <= DRAW;
            bus.vga_x      <= lo(new_x);
            bus.vga_y      <= Y0;
            bus.vga_colour <= COLOUR;
          end else begin
            state    <= FIN;
            bus.plot <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        FIN: begin
          state      <= IDLE;
          bus.done   <= 1'b0;
          drawn_x    <= new_x;
          first_draw <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
